// File: rtl/healthcare_alarm_pkg.sv
// Shared constants for the healthcare alarm scheduler:
// source indices, alarm codes and scheduler state encoding.
package healthcare_alarm_pkg;

  localparam int NUM_SRC   = 5;

  localparam int SRC_FALL  = 0;
  localparam int SRC_NERV  = 1;
  localparam int SRC_BLOOD = 2;
  localparam int SRC_PRES  = 3;
  localparam int SRC_TEMP  = 4;

  localparam logic [2:0] ALARM_NONE  = 3'd0;
  localparam logic [2:0] ALARM_FALL  = 3'd1;
  localparam logic [2:0] ALARM_NERV  = 3'd2;
  localparam logic [2:0] ALARM_BLOOD = 3'd3;
  localparam logic [2:0] ALARM_PRES  = 3'd4;
  localparam logic [2:0] ALARM_TEMP  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESENT,
    ST_ESCALATE,
    ST_HOLDOFF
  } alarm_state_e;

  // Lowest set index wins; code is index+1.
  function automatic logic [2:0] pick_code(
    input logic [NUM_SRC-1:0] pend
  );
    logic [2:0] c;
    c = ALARM_NONE;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pend[i]) c = 3'(i + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/persistence_filter.sv
// Debounce one abnormality source and hold a sticky
// pending request until the scheduler clears it.
module persistence_filter #(
  parameter int PERSIST_CYCLES = 4,
  parameter int CNT_W          = 5
) (
  input  logic clock,
  input  logic resetN,
  input  logic src_i,
  input  logic clr_i,
  output logic pend_o
);

  localparam logic [CNT_W-1:0] PMAX =
    CNT_W'(PERSIST_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rearm_q, rearm_d;
  logic             pend_q, pend_d;
  logic             set_w;

  always_comb begin
    cnt_d   = cnt_q;
    rearm_d = rearm_q;
    set_w   = 1'b0;
    if (src_i) begin
      if (cnt_q != PMAX) cnt_d = cnt_q + 1'b1;
      if (cnt_d == PMAX && rearm_q) begin
        set_w   = 1'b1;
        rearm_d = 1'b0;
      end
    end else begin
      cnt_d   = '0;
      rearm_d = 1'b1;
    end
    // A fresh persistence on the serve edge is a new request.
    pend_d = set_w | (pend_q & ~clr_i);
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      cnt_q   <= '0;
      rearm_q <= 1'b1;
      pend_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rearm_q <= rearm_d;
      pend_q  <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/abnormality_alarm_scheduler.sv
// Debounces five abnormality sources and presents them one at
// a time on a shared valid/ack alarm channel by fixed priority.
module abnormality_alarm_scheduler
  import healthcare_alarm_pkg::*;
#(
  parameter int PERSIST_CYCLES = 4,
  parameter int ACK_TIMEOUT    = 16,
  parameter int HOLDOFF_CYCLES = 2,
  parameter int CNT_W          = 5
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic       fallDetected,
  input  logic [1:0] nervousAbnormality,
  input  logic       bloodAbnormality,
  input  logic       presureAbnormality,
  input  logic       temperatureAbnormality,
  input  logic       alarmAck,
  output logic       alarmValid,
  output logic [2:0] alarmCode,
  output logic       escalate,
  output logic [4:0] pendingMask
);

  localparam logic [CNT_W-1:0] TMO =
    CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] HLD =
    CNT_W'(HOLDOFF_CYCLES);

  logic [NUM_SRC-1:0] src;
  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] clr;

  alarm_state_e     state_q, state_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  assign src[SRC_FALL]  = fallDetected;
  assign src[SRC_NERV]  = |nervousAbnormality;
  assign src[SRC_BLOOD] = bloodAbnormality;
  assign src[SRC_PRES]  = presureAbnormality;
  assign src[SRC_TEMP]  = temperatureAbnormality;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_pf
    persistence_filter #(
      .PERSIST_CYCLES (PERSIST_CYCLES),
      .CNT_W          (CNT_W)
    ) u_pf (
      .clock  (clock),
      .resetN (resetN),
      .src_i  (src[g]),
      .clr_i  (clr[g]),
      .pend_o (pend[g])
    );
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_IDLE;
      code_q  <= ALARM_NONE;
      tmo_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    tmo_d   = tmo_q;
    hold_d  = hold_q;
    clr     = '0;
    unique case (state_q)
      ST_IDLE: begin
        tmo_d  = '0;
        hold_d = '0;
        if (|pend) begin
          state_d = ST_PRESENT;
          code_d  = pick_code(pend);
        end
      end
      ST_PRESENT, ST_ESCALATE: begin
        if (tmo_q != TMO) tmo_d = tmo_q + 1'b1;
        if (alarmAck) begin
          for (int i = 0; i < NUM_SRC; i++) begin
            clr[i] = (code_q == 3'(i + 1));
          end
          code_d  = ALARM_NONE;
          tmo_d   = '0;
          hold_d  = '0;
          state_d = (HOLDOFF_CYCLES == 0) ?
                    ST_IDLE : ST_HOLDOFF;
        end else if (state_q == ST_PRESENT &&
                     tmo_d == TMO) begin
          state_d = ST_ESCALATE;
        end
      end
      ST_HOLDOFF: begin
        if (hold_q != HLD) hold_d = hold_q + 1'b1;
        if (hold_d == HLD) begin
          state_d = ST_IDLE;
          hold_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    alarmValid  = (state_q == ST_PRESENT) ||
                  (state_q == ST_ESCALATE);
    escalate    = (state_q == ST_ESCALATE);
    alarmCode   = code_q;
    pendingMask = pend;
  end

endmodule

// File: tb/tb_abnormality_alarm_scheduler.sv
// Random and directed stimulus against a behavioural model
// of the alarm scheduler, compared on every falling edge.
module tb_abnormality_alarm_scheduler;

  localparam int P   = 4;
  localparam int TMO = 16;
  localparam int HLD = 2;

  logic       clock  = 1'b0;
  logic       resetN = 1'b0;
  logic       fall   = 1'b0;
  logic [1:0] nerv   = 2'd0;
  logic       blood  = 1'b0;
  logic       pres   = 1'b0;
  logic       temp   = 1'b0;
  logic       ack    = 1'b0;
  logic       alarmValid;
  logic [2:0] alarmCode;
  logic       escalate;
  logic [4:0] pendingMask;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  abnormality_alarm_scheduler #(
    .PERSIST_CYCLES (P),
    .ACK_TIMEOUT    (TMO),
    .HOLDOFF_CYCLES (HLD),
    .CNT_W          (5)
  ) dut (
    .clock                  (clock),
    .resetN                 (resetN),
    .fallDetected           (fall),
    .nervousAbnormality     (nerv),
    .bloodAbnormality       (blood),
    .presureAbnormality     (pres),
    .temperatureAbnormality (temp),
    .alarmAck               (ack),
    .alarmValid             (alarmValid),
    .alarmCode              (alarmCode),
    .escalate               (escalate),
    .pendingMask            (pendingMask)
  );

  // Model: high-sample run length, armed flag, pending set,
  // index being served (-1 none), cycles waited, hold left.
  int       m_run[5];
  bit       m_armed[5];
  bit [4:0] m_pend;
  int       m_serv;
  int       m_wait;
  bit       m_esc;
  int       m_hold;

  task automatic m_reset();
    for (int i = 0; i < 5; i++) begin
      m_run[i]   = 0;
      m_armed[i] = 1'b1;
    end
    m_pend = '0;
    m_serv = -1;
    m_wait = 0;
    m_esc  = 1'b0;
    m_hold = 0;
  endtask

  task automatic m_step();
    bit       hi[5];
    bit [4:0] newp;
    bit [4:0] old;
    int       served;
    newp   = '0;
    old    = m_pend;
    served = -1;
    hi     = '{fall, (nerv != 2'd0), blood, pres, temp};
    for (int i = 0; i < 5; i++) begin
      if (hi[i]) begin
        if (m_run[i] < P) m_run[i]++;
        if (m_run[i] == P && m_armed[i]) begin
          newp[i]    = 1'b1;
          m_armed[i] = 1'b0;
        end
      end else begin
        m_run[i]   = 0;
        m_armed[i] = 1'b1;
      end
    end
    if (m_serv >= 0) begin
      if (ack) begin
        served = m_serv;
        m_serv = -1;
        m_esc  = 1'b0;
        m_hold = HLD;
      end else begin
        m_wait++;
        if (m_wait >= TMO) m_esc = 1'b1;
      end
    end else if (m_hold > 0) begin
      m_hold--;
    end else if (old != 5'd0) begin
      for (int i = 4; i >= 0; i--) begin
        if (old[i]) m_serv = i;
      end
      m_wait = 0;
    end
    m_pend = newp | old;
    if (served >= 0) m_pend[served] = newp[served];
  endtask

  always @(posedge clock or negedge resetN) begin
    if (!resetN) m_reset();
    else         m_step();
  end

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    check("valid", 32'(alarmValid), 32'(m_serv >= 0));
    check("code", 32'(alarmCode),
          (m_serv >= 0) ? 32'(m_serv + 1) : 32'd0);
    check("escalate", 32'(escalate), 32'(m_esc));
    check("pending", 32'(pendingMask), 32'(m_pend));
  end

  task automatic step(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic lit(
    input logic       v,
    input logic [2:0] c,
    input logic       e,
    input logic [4:0] m
  );
    check("lit_valid", 32'(alarmValid), 32'(v));
    check("lit_code", 32'(alarmCode), 32'(c));
    check("lit_esc", 32'(escalate), 32'(e));
    check("lit_mask", 32'(pendingMask), 32'(m));
  endtask

  initial begin
    int rate;
    m_reset();
    // Reset held with toggling inputs.
    for (int i = 0; i < 6; i++) begin
      step();
      lit(0, 0, 0, 5'b00000);
      {fall, nerv, blood, pres, temp, ack} =
        7'($urandom);
    end
    {fall, nerv, blood, pres, temp, ack} = '0;
    step();
    resetN = 1'b1;
    step(2);

    // Debounce: 3 edges is too short, 4 edges pends.
    fall = 1'b1;
    step(3);
    fall = 1'b0;
    lit(0, 0, 0, 5'b00000);
    step(2);
    lit(0, 0, 0, 5'b00000);
    fall = 1'b1;
    step(3);
    lit(0, 0, 0, 5'b00000);
    step();
    lit(0, 0, 0, 5'b00001);
    step();
    lit(1, 1, 0, 5'b00001);
    ack = 1'b1;
    step();
    lit(0, 0, 0, 5'b00000);
    ack = 1'b0;
    step(6);
    lit(0, 0, 0, 5'b00000);
    fall = 1'b0;
    step(3);

    // Priority: fall beats blood, blood after hold-off.
    fall  = 1'b1;
    blood = 1'b1;
    step(4);
    lit(0, 0, 0, 5'b00101);
    step();
    lit(1, 1, 0, 5'b00101);
    ack = 1'b1;
    step();
    lit(0, 0, 0, 5'b00100);
    ack = 1'b0;
    step(2);
    lit(0, 0, 0, 5'b00100);
    step();
    lit(1, 3, 0, 5'b00100);
    ack = 1'b1;
    step();
    ack   = 1'b0;
    fall  = 1'b0;
    blood = 1'b0;
    step(4);

    // Escalation after 16 unacked edges.
    nerv = 2'd2;
    step(4);
    lit(0, 0, 0, 5'b00010);
    step();
    lit(1, 2, 0, 5'b00010);
    step(15);
    lit(1, 2, 0, 5'b00010);
    step();
    lit(1, 2, 1, 5'b00010);
    ack = 1'b1;
    step();
    lit(0, 0, 0, 5'b00000);
    ack  = 1'b0;
    nerv = 2'd0;
    step(4);

    // Ack on the 16th edge: escalate never rises.
    nerv = 2'd1;
    step(5);
    lit(1, 2, 0, 5'b00010);
    step(15);
    ack = 1'b1;
    step();
    lit(0, 0, 0, 5'b00000);
    ack  = 1'b0;
    nerv = 2'd0;
    step(4);

    // Rearm: held source does not re-pend.
    temp = 1'b1;
    step(5);
    lit(1, 5, 0, 5'b10000);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step(8);
    lit(0, 0, 0, 5'b00000);
    temp = 1'b0;
    step();
    temp = 1'b1;
    step(3);
    lit(0, 0, 0, 5'b00000);
    step();
    lit(0, 0, 0, 5'b10000);
    step();
    lit(1, 5, 0, 5'b10000);
    ack = 1'b1;
    step();
    ack  = 1'b0;
    temp = 1'b0;
    step(4);

    // Asynchronous reset mid-PRESENT.
    pres = 1'b1;
    step(5);
    lit(1, 4, 0, 5'b01000);
    #2 resetN = 1'b0;
    #1 lit(0, 0, 0, 5'b00000);
    step();
    resetN = 1'b1;
    step(3);
    lit(0, 0, 0, 5'b00000);
    step();
    lit(0, 0, 0, 5'b01000);
    step();
    lit(1, 4, 0, 5'b01000);
    ack = 1'b1;
    step();
    ack  = 1'b0;
    pres = 1'b0;
    step(4);

    // Randomised traffic with varying ack eagerness.
    rate = 4;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 2))
          0:       rate = 1;
          1:       rate = 5;
          default: rate = 40;
        endcase
      end
      if ($urandom_range(0, 5) == 0) fall  = ~fall;
      if ($urandom_range(0, 5) == 0) blood = ~blood;
      if ($urandom_range(0, 5) == 0) pres  = ~pres;
      if ($urandom_range(0, 5) == 0) temp  = ~temp;
      if ($urandom_range(0, 5) == 0) begin
        nerv = (nerv != 2'd0) ? 2'd0 :
               2'($urandom_range(1, 3));
      end
      ack = ($urandom_range(0, rate) == 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 resetN = 1'b0;
        step();
        resetN = 1'b1;
      end else begin
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/abnormality_alarm_scheduler.md
Name: abnormality_alarm_scheduler

Overview:
- Sequences the five abnormality inputs of the healthcare controller onto one shared alarm/notification channel.
- Each source is debounced by a persistence filter, then latched as a sticky pending request.
- Pending requests are served one at a time by fixed priority, using a valid/ack handshake.
- A missing acknowledge escalates after a timeout. A hold-off gap separates consecutive alarms.

Parameters:
- PERSIST_CYCLES, 4: number of consecutive high samples before a source becomes pending (must be ≥1).
- ACK_TIMEOUT, 16: cycles in PRESENT without ack before escalation (must be ≥1).
- HOLDOFF_CYCLES, 2: idle cycles forced after each acknowledged alarm (0 allowed: go straight to IDLE).
- CNT_W, 5: width of the persistence, timeout and hold-off counters. It must hold the largest of the three values above.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- fallDetected  in  1  source 0, highest priority.
- nervousAbnormality  in  2  source 1; active when nonzero.
- bloodAbnormality  in  1  source 2.
- presureAbnormality  in  1  source 3.
- temperatureAbnormality  in  1  source 4, lowest priority.
- alarmAck  in  1  acknowledge from the alarm consumer.
- alarmValid  out  1  an alarm is being presented.
- alarmCode  out  3  0 none, 1 fall, 2 nervous, 3 blood, 4 pressure, 5 temperature.
- escalate  out  1  the presented alarm is unacknowledged beyond ACK_TIMEOUT.
- pendingMask  out  5  bit i = source i pending (includes the source being presented).

Behaviour:
- Reset: while resetN=0, immediately (asynchronously) all outputs are 0, all counters are 0, all rearm flags are 1, and the state is IDLE.
- Persistence filter, per source:
  - While the input is sampled high, the counter increments, saturating at PERSIST_CYCLES.
  - A low sample clears the counter and sets rearm.
  - On the edge where the count reaches PERSIST_CYCLES with rearm=1, the pending bit is set and rearm is cleared.
  - Pending is sticky: the source dropping afterwards does not clear it.
  - A source still high when its alarm is acked does not re-pend. It must go low for ≥1 cycle and then persist again.
- FSM states: IDLE, PRESENT, ESCALATE, HOLDOFF.
  - IDLE: alarmValid=0. If pendingMask≠0, on the next edge select the lowest set index, register alarmCode=index+1, and go to PRESENT. Clear the timeout counter.
  - PRESENT: alarmValid=1 and alarmCode held. The timeout counter increments each edge.
    - alarmAck=1 → clear the served pending bit, set alarmValid=0 and alarmCode=0, go to HOLDOFF (or IDLE if HOLDOFF_CYCLES=0).
    - Counter reaches ACK_TIMEOUT without ack → go to ESCALATE.
  - ESCALATE: alarmValid=1, escalate=1, code held. alarmAck=1 → same exit as PRESENT; escalate drops on the same edge.
  - HOLDOFF: alarmValid=0. Count HOLDOFF_CYCLES edges, then go to IDLE. Pending bits may still set during HOLDOFF.
- Latency:
  - A source rising before edge k is pending after edge k+PERSIST_CYCLES-1.
  - alarmValid rises one edge later, if the FSM is in IDLE.
- Boundary rules:
  - No preemption: a higher-priority source pending during PRESENT/ESCALATE waits.
  - Ack and timeout expiry on the same edge: ack wins, no escalate.
  - alarmAck outside PRESENT/ESCALATE is ignored. A held ack serves at most one alarm per PRESENT entry.
  - A served source re-pending during HOLDOFF is served again after HOLDOFF, by priority.
  - Counters saturate and never wrap.
  - Reset mid-handshake drops alarmValid and escalate immediately and discards all pending requests.

Decomposition:
- Package healthcare_alarm_pkg holds:
  - the source index constants SRC_FALL=0 … SRC_TEMP=4;
  - the alarm code constants ALARM_NONE=0 … ALARM_TEMP=5;
  - the FSM state encoding.
- One sub-module, persistence_filter (counter, rearm flag, pending flag, with clear input), instantiated five times.
- Priority select and FSM live in the top level.

Test Plan (defaults):
- Reset: hold resetN=0 with all inputs toggling → alarmValid=0, alarmCode=0, escalate=0, pendingMask=5'b00000 throughout.
- Debounce: fallDetected high for 3 edges then low → pendingMask stays 0. High for 4 edges → pendingMask=5'b00001, then alarmValid=1, alarmCode=1 one edge later.
- Priority:
  - Stimulus: bloodAbnormality=1 and fallDetected=1 in the same cycle, both held.
  - Required: pendingMask=5'b00101 and alarmCode=1 presented first.
  - Ack → alarmValid=0 for 2 cycles (HOLDOFF), then alarmCode=3.
- Escalation: nervousAbnormality=2 persists, no ack → escalate=1 on the 16th PRESENT edge, alarmCode=2 held. Ack → alarmValid=0 and escalate=0 on the same edge. Ack coincident with the 16th edge → escalate never rises.
- Rearm: temperatureAbnormality held high through its ack → no second alarm. Drop for 1 cycle, then high for 4 edges → alarmCode=5 presented again.
- Async reset: resetN=0 mid-PRESENT between edges → alarmValid and pendingMask go to 0 without a clock edge. After release, the FSM is in IDLE and filters need a fresh 4-edge persistence.
